// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencer that owns the enable of an up-counter.
// It drives en in bursts of cfg_limit unpaused cycles, repeated cfg_reps
// times, with GAP_CYC unpaused idle cycles between bursts. It also provides
// pause, stop/abort and completion signalling.
//
// Optional feature (macro COUNTER_SEQ_CTRL_CHECK_EN): adds the count input,
// which is the counter's output, and the sticky err output. err flags any busy
// cycle in which count differs from the value implied by the enables issued.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, stop, pause  request, abort, freeze
//   cfg_limit, cfg_reps burst length L and burst count R (sampled at accept)
//   en                  counter enable (registered state gated by live pause)
//   busy                sequence in progress (RUN or GAP)
//   seg_done            last enable cycle of each burst
//   done, abort         one-cycle completion / abort pulses
//   rep_idx             0-based index of current burst
//   count, err          (optional) counter value in, sticky mismatch flag out
module counter_seq_ctrl #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned REPS_W  = 4,
   parameter int unsigned GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [WIDTH-1:0]  cfg_limit,
   input  logic [REPS_W-1:0] cfg_reps,
`ifdef COUNTER_SEQ_CTRL_CHECK_EN
   input  logic [WIDTH-1:0]  count,
   output logic              err,
`endif
   output logic              en,
   output logic              busy,
   output logic              seg_done,
   output logic              done,
   output logic              abort,
   output logic [REPS_W-1:0] rep_idx
);

   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [WIDTH-1:0]    seg_cnt, seg_cnt_d;
   logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
   logic [REPS_W-1:0]   rep_idx_d;
   logic [WIDTH-1:0]    l_q, l_d;
   logic [REPS_W-1:0]   r_q, r_d;
   logic                abort_d;
   logic                accept_c;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         seg_cnt <= '0;
         gap_cnt <= '0;
         rep_idx <= '0;
         l_q     <= '0;
         r_q     <= '0;
         abort   <= 1'b0;
      end else begin
         state   <= state_d;
         seg_cnt <= seg_cnt_d;
         gap_cnt <= gap_cnt_d;
         rep_idx <= rep_idx_d;
         l_q     <= l_d;
         r_q     <= r_d;
         abort   <= abort_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state;
      seg_cnt_d = seg_cnt;
      gap_cnt_d = gap_cnt;
      rep_idx_d = rep_idx;
      l_d       = l_q;
      r_d       = r_q;
      abort_d   = 1'b0;
      accept_c  = 1'b0;

      en       = (state == S_RUN) && !pause;
      busy     = (state == S_RUN) || (state == S_GAP);
      done     = (state == S_DONE);
      seg_done = en && (seg_cnt == (l_q - WIDTH'(1)));

      case (state)
         S_IDLE: begin
            // stop has priority over a simultaneous start
            if (start && !stop) begin
               accept_c  = 1'b1;
               l_d       = cfg_limit;
               r_d       = cfg_reps;
               seg_cnt_d = '0;
               rep_idx_d = '0;
               state_d   = ((cfg_limit == '0) || (cfg_reps == '0)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else if (seg_done) begin
               seg_cnt_d = '0;
               if (rep_idx == (r_q - REPS_W'(1))) begin
                  state_d = S_DONE;
               end else begin
                  rep_idx_d = rep_idx + REPS_W'(1);
                  gap_cnt_d = '0;
                  state_d   = S_GAP;
               end
            end else if (en) begin
               seg_cnt_d = seg_cnt + WIDTH'(1);
            end
         end
         S_GAP: begin
            if (stop) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else if (!pause) begin
               if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                  gap_cnt_d = '0;
                  state_d   = S_RUN;
               end else begin
                  gap_cnt_d = gap_cnt + GAP_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef COUNTER_SEQ_CTRL_CHECK_EN
   logic [WIDTH-1:0] exp_cnt;

   // Shadow of the counter; err is sticky until the next accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_cnt <= '0;
         err     <= 1'b0;
      end else if (accept_c) begin
         exp_cnt <= count;
         err     <= 1'b0;
      end else begin
         exp_cnt <= exp_cnt + WIDTH'(en);
         if (busy && (count != exp_cnt)) begin
            err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl. A reference model tracks each
// sequence as a position in a flat timeline of unpaused slots, and includes
// a simple up-counter that is driven by the DUT's en.
module tb_counter_seq_ctrl;
   localparam int unsigned W   = 4;
   localparam int unsigned RW  = 4;
   localparam int unsigned GAP = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop, pause;
   logic [W-1:0]  cfg_limit;
   logic [RW-1:0] cfg_reps;
   logic          en, busy, seg_done, done, abort;
   logic [RW-1:0] rep_idx;
   logic [W-1:0]  count;
`ifdef COUNTER_SEQ_CTRL_CHECK_EN
   logic          err;
`endif

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(W), .REPS_W(RW), .GAP_CYC(GAP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .cfg_limit (cfg_limit),
      .cfg_reps  (cfg_reps),
`ifdef COUNTER_SEQ_CTRL_CHECK_EN
      .count     (count),
      .err       (err),
`endif
      .en        (en),
      .busy      (busy),
      .seg_done  (seg_done),
      .done      (done),
      .abort     (abort),
      .rep_idx   (rep_idx)
   );

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit         m_active, m_done_pend, m_abort_pend, m_err, skip_en;
   int         m_p, m_l, m_r, m_rep, en_since;
   logic [W-1:0] start_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_active = 0; m_done_pend = 0; m_abort_pend = 0; m_err = 0;
      m_p = 0; m_l = 0; m_r = 0; m_rep = 0; en_since = 0; start_cnt = '0;
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance model after posedge.
   task automatic step(input bit s, input bit st, input bit p, input int l, input int r);
      int per, off, b, total;
      bit e_en, e_sd, e_busy, e_done, e_abort, en_seen;
      int e_rep;
      logic [W-1:0] cnt_old;
      start = s; stop = st; pause = p;
      cfg_limit = W'(l); cfg_reps = RW'(r);
      per = m_l + GAP;
      total = m_r * m_l + (m_r - 1) * GAP;
      e_en = 0; e_sd = 0; e_busy = 0; e_rep = m_rep;
      if (m_active) begin
         off = m_p % per;
         b = m_p / per;
         e_busy = 1;
         e_en = (off < m_l) && !p;
         e_sd = e_en && (off == m_l - 1);
         e_rep = (off < m_l) ? b : b + 1;
      end
      e_done = m_done_pend;
      e_abort = m_abort_pend;
      m_rep = e_rep;
      @(negedge clk);
      check_eq("en", en, e_en);
      check_eq("busy", busy, e_busy);
      check_eq("seg_done", seg_done, e_sd);
      check_eq("done", done, e_done);
      check_eq("abort", abort, e_abort);
      check_eq("rep_idx", rep_idx, RW'(e_rep));
`ifdef COUNTER_SEQ_CTRL_CHECK_EN
      check_eq("err", err, m_err);
`endif
      en_seen = en;
      @(posedge clk);
      #1;
      cnt_old = count;
      m_abort_pend = 0;
      m_done_pend = 0;
      if (m_active) begin
         if (cnt_old != W'(start_cnt + W'(en_since))) m_err = 1;
         en_since += int'(e_en);
         if (st) begin
            m_active = 0;
            m_abort_pend = 1;
         end else if (!p) begin
            if (m_p == total - 1) begin
               m_active = 0;
               m_done_pend = 1;
            end else begin
               m_p++;
            end
         end
      end else if (!e_done && s && !st) begin
         m_l = l; m_r = r; m_rep = 0;
         start_cnt = cnt_old; en_since = 0; m_err = 0;
         if (l == 0 || r == 0) m_done_pend = 1;
         else begin
            m_active = 1;
            m_p = 0;
         end
      end
      if (en_seen && !skip_en) count = count + W'(1);
      skip_en = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [W-1:0] c0;
      rst_n = 1'b0; start = 0; stop = 0; pause = 0;
      cfg_limit = '0; cfg_reps = '0; count = '0; skip_en = 0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_en", en, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_abort", abort, 0);
      check_eq("rst_seg_done", seg_done, 0);
      check_eq("rst_rep_idx", rep_idx, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // basic L=3 R=2
      c0 = count;
      step(1, 0, 0, 3, 2);
      idle(10);
      check_eq("basic_count_adv", 32'(W'(count - c0)), 6);

      // pause during cycles 1-2 of an L=4 R=1 burst
      c0 = count;
      step(1, 0, 0, 4, 1);
      for (int i = 0; i < 9; i++) step(0, 0, (i == 1 || i == 2), 0, 0);
      check_eq("pause_count_adv", 32'(W'(count - c0)), 4);

      // stop mid-burst
      step(1, 0, 0, 5, 3);
      for (int i = 0; i < 6; i++) step(0, (i == 2), 0, 0, 0);

      // degenerate configurations
      step(1, 0, 0, 0, 2);
      idle(3);
      step(1, 0, 0, 3, 0);
      idle(3);

      // start held high while busy with different cfg, then start+stop in idle
      step(1, 0, 0, 3, 2);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 7, 5);
      idle(3);
      step(1, 1, 0, 4, 4);
      step(1, 1, 0, 4, 4);
      idle(2);

      // async reset during cycle 4 of an L=15 burst
      step(1, 0, 0, 15, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_en", en, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_done", done, 0);
      check_eq("arst_abort", abort, 0);
      check_eq("arst_rep_idx", rep_idx, 0);
      reset_model();
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      idle(2);

      // counter wrap with a good counter, then with one dropped enable
      count = W'(9);
      step(1, 0, 0, 15, 2);
      idle(36);
      step(1, 0, 0, 15, 2);
      for (int i = 0; i < 36; i++) begin
         skip_en = (i == 5);
         step(0, 0, 0, 0, 0);
      end
      step(1, 0, 0, 2, 1);
      idle(5);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         skip_en = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 4) == 0, int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)));
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
